// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - RV32I load/store width codes (funct3)
//   - responder FSM state encoding
//   - latency counter sizing
//   - funct3 legality helper
// -----------------------------------------------------------------------------
package dmem_pkg;

    // Upper bound of the LATENCY parameter; sizes the BUSY down-counter.
    localparam int MAX_LATENCY = 8;
    localparam int CNT_W       = $clog2(MAX_LATENCY);

    // RV32I width codes.
    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Unsigned load codes have no store counterpart, so they are only
    // legal on loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane logic for the data-memory responder.
//   Loads : picks the byte/halfword lane from the stored word and sign- or
//           zero-extends it to 32 bits.
//   Stores: generates the per-byte write enables and replicates the store
//           data onto every lane so the enabled lanes pick it up.
//   Also flags misaligned accesses and illegal width codes.
//
// Ports
//   i_we       1   1 = store, 0 = load
//   i_funct3   3   RV32I width code
//   i_addr_lo  2   byte offset inside the word (addr[1:0])
//   i_wdata    32  store data, LSB-aligned
//   i_rword    32  word currently held at the addressed index
//   o_be       4   byte write enables (all zero for loads/illegal codes)
//   o_wdata    32  store data replicated onto the byte lanes
//   o_rdata    32  extended load data (zero for illegal codes)
//   o_err      1   misaligned access or illegal funct3
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_misaligned;

    // Byte lane selected by the low address bits.
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'b00:   w_byte = i_rword[7:0];
            2'b01:   w_byte = i_rword[15:8];
            2'b10:   w_byte = i_rword[23:16];
            2'b11:   w_byte = i_rword[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    // Halfword lane: only addr[1] matters, addr[0]=1 is caught as misaligned.
    always_comb begin
        w_half = 16'h0000;
        if (i_addr_lo[1]) begin
            w_half = i_rword[31:16];
        end else begin
            w_half = i_rword[15:0];
        end
    end

    // Load extension by width code.
    always_comb begin
        o_rdata = 32'h0000_0000;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_W:    o_rdata = i_rword;
            F3_BU:   o_rdata = {24'h00_0000, w_byte};
            F3_HU:   o_rdata = {16'h0000, w_half};
            default: o_rdata = 32'h0000_0000;
        endcase
    end

    // Store byte enables and lane-replicated store data.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
        if (i_we) begin
            case (i_funct3)
                F3_B: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                F3_H: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                F3_W: begin
                    o_be    = 4'b1111;
                    o_wdata = i_wdata;
                end
                default: begin
                    o_be    = 4'b0000;
                    o_wdata = 32'h0000_0000;
                end
            endcase
        end else begin
            o_be    = 4'b0000;
            o_wdata = 32'h0000_0000;
        end
    end

    // Alignment check: halfwords need addr[0]=0, words need addr[1:0]=0.
    always_comb begin
        w_misaligned = 1'b0;
        case (i_funct3)
            F3_H, F3_HU: w_misaligned = i_addr_lo[0];
            F3_W:        w_misaligned = (i_addr_lo != 2'b00);
            default:     w_misaligned = 1'b0;
        endcase
    end

    assign o_err = w_misaligned | ~f3_legal(i_we, i_funct3);

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder for an RV32I core. A request is
// accepted in IDLE, optionally held in BUSY for LATENCY-1 cycles, and its
// response is presented in RESP until the core takes it. Stores commit on
// the edge that enters RESP; errored stores write nothing.
//
// Parameters
//   DEPTH_WORDS  storage size in 32-bit words (power of two, 16..65536)
//   LATENCY      acceptance-to-response latency in cycles (1..8)
//
// Ports
//   clk         1   clock, rising edge
//   reset       1   synchronous active-low reset
//   req_valid   1   request present
//   req_ready   1   responder idle and able to accept
//   req_addr    32  byte address
//   req_we      1   1 = store, 0 = load
//   req_funct3  3   RV32I width code
//   req_wdata   32  store data, LSB-aligned
//   resp_valid  1   response present
//   resp_ready  1   core accepts the response
//   resp_rdata  32  extended load data, 0 for stores and errors
//   resp_err    1   misaligned, out-of-range or illegal funct3
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int              IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // State and captured request.
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic             r_we;
    logic [2:0]       r_funct3;
    logic [31:0]      r_wdata;

    // Registered outputs.
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    // Storage (never reset).
    logic [31:0] r_mem [DEPTH_WORDS];

    // Combinational nets.
    state_e           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_accept;
    logic             w_enter_resp;
    logic [31:0]      w_addr;
    logic             w_we;
    logic [2:0]       w_funct3;
    logic [31:0]      w_wdata;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rword;
    logic             w_range_err;
    logic             w_lane_err;
    logic             w_err;
    logic             w_commit;
    logic [3:0]       w_be;
    logic [31:0]      w_lane_wdata;
    logic [31:0]      w_lane_rdata;
    logic             w_nxt_req_ready;
    logic             w_nxt_resp_valid;
    logic [31:0]      w_nxt_resp_rdata;
    logic             w_nxt_resp_err;

    assign w_accept = (r_state == ST_IDLE) && r_req_ready && req_valid;

    // While IDLE the live request is the transaction; this matters only for
    // LATENCY=1, where the acceptance edge is also the commit edge. Once
    // accepted, only the captured copy is used.
    assign w_addr   = (r_state == ST_IDLE) ? req_addr   : r_addr;
    assign w_we     = (r_state == ST_IDLE) ? req_we     : r_we;
    assign w_funct3 = (r_state == ST_IDLE) ? req_funct3 : r_funct3;
    assign w_wdata  = (r_state == ST_IDLE) ? req_wdata  : r_wdata;

    assign w_idx       = w_addr[IDX_W+1:2];
    assign w_rword     = r_mem[w_idx];
    assign w_range_err = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_err       = w_range_err | w_lane_err;

    dmem_lane_align u_lane_align (
        .i_we      (w_we),
        .i_funct3  (w_funct3),
        .i_addr_lo (w_addr[1:0]),
        .i_wdata   (w_wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wdata   (w_lane_wdata),
        .o_rdata   (w_lane_rdata),
        .o_err     (w_lane_err)
    );

    // FSM state and BUSY down-counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // FSM next-state and counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_next_state = ST_RESP;
                        w_next_cnt   = CNT_ZERO;
                    end else begin
                        w_next_state = ST_BUSY;
                        w_next_cnt   = CNT_LOAD;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = CNT_ZERO;
                end
            end
            ST_BUSY: begin
                // Counter was loaded with LATENCY-1; leaving at 1 gives
                // exactly LATENCY-1 BUSY cycles.
                if (r_cnt <= CNT_ONE) begin
                    w_next_state = ST_RESP;
                    w_next_cnt   = CNT_ZERO;
                end else begin
                    w_next_state = ST_BUSY;
                    w_next_cnt   = r_cnt - CNT_ONE;
                end
            end
            ST_RESP: begin
                if (r_resp_valid && resp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
                w_next_cnt = CNT_ZERO;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = CNT_ZERO;
            end
        endcase
    end

    assign w_enter_resp = (r_state != ST_RESP) && (w_next_state == ST_RESP);
    assign w_commit     = w_enter_resp && w_we && !w_err;

    // Next values of the registered outputs.
    always_comb begin
        w_nxt_req_ready  = (w_next_state == ST_IDLE);
        w_nxt_resp_valid = (w_next_state == ST_RESP);
        w_nxt_resp_rdata = 32'h0000_0000;
        w_nxt_resp_err   = 1'b0;
        if (w_enter_resp) begin
            w_nxt_resp_rdata = (w_we || w_err) ? 32'h0000_0000 : w_lane_rdata;
            w_nxt_resp_err   = w_err;
        end else if (w_next_state == ST_RESP) begin
            // Hold the response stable until it is taken.
            w_nxt_resp_rdata = r_resp_rdata;
            w_nxt_resp_err   = r_resp_err;
        end else begin
            w_nxt_resp_rdata = 32'h0000_0000;
            w_nxt_resp_err   = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
        end else begin
            r_req_ready  <= w_nxt_req_ready;
            r_resp_valid <= w_nxt_resp_valid;
            r_resp_rdata <= w_nxt_resp_rdata;
            r_resp_err   <= w_nxt_resp_err;
        end
    end

    // Request capture on acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr   <= 32'h0000_0000;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_wdata  <= 32'h0000_0000;
        end else if (w_accept) begin
            r_addr   <= req_addr;
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
        end
    end

    // Storage write: only enabled lanes, only for error-free stores, and a
    // reset on the commit edge aborts the write.
    always_ff @(posedge clk) begin
        if (reset && w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_lane_wdata[8*k +: 8];
                end
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Scoreboard bench: two responder instances (A: LATENCY=2, 1024 words;
// B: LATENCY=4, 16 words). The driver pushes the hand-computed response of
// every accepted request into a per-instance queue; monitors pop and compare
// whenever a response handshake is seen, and also check response latency,
// output stability under backpressure and req_ready behaviour.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } sb_t;

    logic        clk;
    logic        rst_a, rst_b;
    logic        req_valid_a, req_ready_a, req_we_a, resp_valid_a, resp_ready_a, resp_err_a;
    logic [31:0] req_addr_a, req_wdata_a, resp_rdata_a;
    logic [2:0]  req_funct3_a;
    logic        req_valid_b, req_ready_b, req_we_b, resp_valid_b, resp_ready_b, resp_err_b;
    logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b;
    logic [2:0]  req_funct3_b;

    sb_t qa[$];
    sb_t qb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset(rst_a),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a),
        .req_we(req_we_a), .req_funct3(req_funct3_a), .req_wdata(req_wdata_a),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(4)) u_dut_b (
        .clk(clk), .reset(rst_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
        .req_we(req_we_b), .req_funct3(req_funct3_b), .req_wdata(req_wdata_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event, required expected handshake", name);
    endtask

    // Present a request and wait (bounded) for acceptance; push expectation.
    task automatic issue(input int sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err, input bit push);
        bit  ok;
        sb_t e;
        ok = 1'b0;
        @(posedge clk);
        #1;
        if (sel == 0) begin
            req_valid_a = 1'b1; req_we_a = we; req_funct3_a = f3; req_addr_a = addr; req_wdata_a = wd;
        end else begin
            req_valid_b = 1'b1; req_we_b = we; req_funct3_b = f3; req_addr_b = addr; req_wdata_b = wd;
        end
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((sel == 0) ? req_ready_a : req_ready_b) begin
                e.rdata = exp_rdata; e.err = exp_err; e.acc = cyc;
                if (push) begin
                    if (sel == 0) qa.push_back(e);
                    else qb.push_back(e);
                end
                ok = 1'b1;
            end
        end
        if (!ok) fail("accept_timeout");
        @(posedge clk);
        #1;
        // Scramble the request lines; the transaction must not notice.
        if (sel == 0) begin
            req_valid_a = 1'b0; req_we_a = ~we; req_funct3_a = 3'b111; req_addr_a = 32'hFFFF_FFFF; req_wdata_a = ~wd;
        end else begin
            req_valid_b = 1'b0; req_we_b = ~we; req_funct3_b = 3'b111; req_addr_b = 32'hFFFF_FFFF; req_wdata_b = ~wd;
        end
    endtask

    task automatic wait_done(input int sel);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (sel == 0) ? (qa.size() == 0) : (qb.size() == 0);
        end
        if (!done) fail("resp_timeout");
    endtask

    task automatic run(input int sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err);
        issue(sel, we, f3, addr, wd, exp_rdata, exp_err, 1'b1);
        wait_done(sel);
    endtask

    // Monitor A: latency, stability, req_ready and scoreboard comparison.
    logic        a_prev_v, a_need_ready, a_snap_e;
    logic [31:0] a_snap_d;
    int          a_first;
    initial begin
        sb_t e;
        a_prev_v = 1'b0; a_need_ready = 1'b0; a_snap_e = 1'b0; a_snap_d = 32'h0; a_first = 0;
        forever begin
            @(negedge clk);
            if (a_need_ready) begin
                chk_b("a_ready_after_resp", req_ready_a, 1'b1);
                a_need_ready = 1'b0;
            end
            if (resp_valid_a === 1'b1) begin
                if (!a_prev_v) begin
                    a_first  = cyc;
                    a_snap_d = resp_rdata_a;
                    a_snap_e = resp_err_a;
                end else begin
                    chk("a_stable_rdata", resp_rdata_a, a_snap_d);
                    chk_b("a_stable_err", resp_err_a, a_snap_e);
                end
                chk_b("a_ready_in_resp", req_ready_a, 1'b0);
                if (resp_ready_a) begin
                    if (qa.size() == 0) begin
                        fail("a_unexpected_resp");
                    end else begin
                        e = qa.pop_front();
                        chk("a_rdata", resp_rdata_a, e.rdata);
                        chk_b("a_err", resp_err_a, e.err);
                        chk("a_latency", 32'(a_first - e.acc), 32'd2);
                    end
                    a_need_ready = 1'b1;
                end
            end
            a_prev_v = (resp_valid_a === 1'b1);
        end
    end

    // Monitor B: latency and scoreboard comparison; any response with an
    // empty queue (e.g. after an aborted store) is an error.
    logic b_prev_v;
    int   b_first;
    initial begin
        sb_t e;
        b_prev_v = 1'b0; b_first = 0;
        forever begin
            @(negedge clk);
            if (resp_valid_b === 1'b1) begin
                if (!b_prev_v) b_first = cyc;
                if (resp_ready_b) begin
                    if (qb.size() == 0) begin
                        fail("b_unexpected_resp");
                    end else begin
                        e = qb.pop_front();
                        chk("b_rdata", resp_rdata_b, e.rdata);
                        chk_b("b_err", resp_err_b, e.err);
                        chk("b_latency", 32'(b_first - e.acc), 32'd4);
                    end
                end
            end
            b_prev_v = (resp_valid_b === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_a = 1'b0; rst_b = 1'b0;
        req_valid_a = 1'b0; req_we_a = 1'b0; req_funct3_a = 3'b000; req_addr_a = 32'h0; req_wdata_a = 32'h0;
        req_valid_b = 1'b0; req_we_b = 1'b0; req_funct3_b = 3'b000; req_addr_b = 32'h0; req_wdata_b = 32'h0;
        resp_ready_a = 1'b1; resp_ready_b = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_b("a_rst_req_ready", req_ready_a, 1'b0);
        chk_b("a_rst_resp_valid", resp_valid_a, 1'b0);
        chk("a_rst_resp_rdata", resp_rdata_a, 32'h0);
        chk_b("a_rst_resp_err", resp_err_a, 1'b0);
        chk_b("b_rst_req_ready", req_ready_b, 1'b0);
        @(posedge clk);
        #1;
        rst_a = 1'b1; rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_b("a_ready_after_release", req_ready_a, 1'b1);
        chk_b("b_ready_after_release", req_ready_b, 1'b1);

        // Word store/load.
        run(0, 1'b1, LW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        run(0, 1'b0, LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Lane selection and extension.
        run(0, 1'b1, LW,  32'h20, 32'h80FF7F01, 32'h0, 1'b0);
        run(0, 1'b0, LB,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0);
        run(0, 1'b0, LBU, 32'h23, 32'h0, 32'h00000080, 1'b0);
        run(0, 1'b0, LH,  32'h22, 32'h0, 32'hFFFF80FF, 1'b0);
        run(0, 1'b0, LHU, 32'h22, 32'h0, 32'h000080FF, 1'b0);
        run(0, 1'b0, LB,  32'h20, 32'h0, 32'h00000001, 1'b0);
        run(0, 1'b0, LH,  32'h20, 32'h0, 32'h00007F01, 1'b0);
        run(0, 1'b0, LB,  32'h21, 32'h0, 32'h0000007F, 1'b0);

        // Byte store into a known word.
        run(0, 1'b1, LW, 32'h20, 32'h11111111, 32'h0, 1'b0);
        run(0, 1'b1, LB, 32'h21, 32'h000000AA, 32'h0, 1'b0);
        run(0, 1'b0, LW, 32'h20, 32'h0, 32'h1111AA11, 1'b0);

        // Errors: misaligned, out of range, illegal funct3; memory untouched.
        run(0, 1'b0, LW,     32'h22,   32'h0,        32'h0, 1'b1);
        run(0, 1'b1, LH,     32'h21,   32'hFFFFFFFF, 32'h0, 1'b1);
        run(0, 1'b0, LW,     32'h1000, 32'h0,        32'h0, 1'b1);
        run(0, 1'b1, LW,     32'h1020, 32'h55555555, 32'h0, 1'b1);
        run(0, 1'b1, LBU,    32'h20,   32'h00000099, 32'h0, 1'b1);
        run(0, 1'b0, 3'b011, 32'h20,   32'h0,        32'h0, 1'b1);
        run(0, 1'b0, LW,     32'h20,   32'h0, 32'h1111AA11, 1'b0);

        // Halfword store and the last legal word index.
        run(0, 1'b1, LH,  32'h22,  32'hFFFF1234, 32'h0, 1'b0);
        run(0, 1'b0, LW,  32'h20,  32'h0, 32'h1234AA11, 1'b0);
        run(0, 1'b1, LW,  32'hFFC, 32'hA5A55A5A, 32'h0, 1'b0);
        run(0, 1'b0, LHU, 32'hFFE, 32'h0, 32'h0000A5A5, 1'b0);
        run(0, 1'b0, LB,  32'hFFD, 32'h0, 32'h0000005A, 1'b0);

        // Backpressure: hold resp_ready low for 5 cycles in RESP.
        @(posedge clk);
        #1;
        resp_ready_a = 1'b0;
        issue(0, 1'b0, LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (resp_valid_a === 1'b1);
        end
        if (!ok) fail("a_bp_no_resp");
        repeat (5) @(posedge clk);
        #1;
        resp_ready_a = 1'b1;
        wait_done(0);

        // Instance B (LATENCY=4, 16 words).
        run(1, 1'b1, LW, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0);
        run(1, 1'b0, LW, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);
        run(1, 1'b1, LW, 32'h3C, 32'h0BADF00D, 32'h0, 1'b0);
        run(1, 1'b0, LW, 32'h3C, 32'h0, 32'h0BADF00D, 1'b0);
        run(1, 1'b0, LW, 32'h40, 32'h0, 32'h0, 1'b1);

        // Reset abort: reset sampled one cycle after acceptance.
        issue(1, 1'b1, LW, 32'h30, 32'h12345678, 32'h0, 1'b0, 1'b0);
        rst_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_b("b_abort_resp_valid", resp_valid_b, 1'b0);
        chk_b("b_abort_req_ready", req_ready_b, 1'b0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_b("b_abort_ready_release", req_ready_b, 1'b1);
        repeat (6) @(negedge clk);
        chk_b("b_abort_no_resp", resp_valid_b, 1'b0);
        run(1, 1'b0, LW, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
